asrv32_clint: RTL

//  Memory-mapped core-local interruptor on the core's data-memory port (downstream of o_store_data/o_wr_en).

---
 rtl/asrv32_clint.sv | 133 +++++++++++++
 1 files changed

// File: rtl/asrv32_clint.sv
// Core-local interruptor on the data-memory port: msip, mtimecmp and a prescaled shadow mtime.
// 64-bit timer registers are written as a staged low word followed by a committing high word.
module asrv32_clint #(
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
    parameter int          CLK_FREQ_MHZ = 100
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wr_data,
    input  logic [3:0]  i_wr_mask,
    input  logic        i_wr_en,
    output logic        o_sel,
    output logic [31:0] o_rd_data,
    output logic        o_software_interrupt,
    output logic        o_mtime_wr,
    output logic        o_mtimecmp_wr,
    output logic [63:0] o_mtime_dout,
    output logic [63:0] o_mtimecmp_dout
);

    localparam int            PW      = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(CLK_FREQ_MHZ - 1);

    logic [31:0]   off;
    logic          wr_acc, rd_acc, full_mask;

    logic          msip_q, msip_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [31:0]   cmp_stage_q, cmp_stage_d;
    logic [31:0]   time_stage_q, time_stage_d;
    logic [31:0]   snap_q, snap_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic          mtime_wr_q, mtime_wr_d;
    logic          mtimecmp_wr_q, mtimecmp_wr_d;

    // Unsigned offset compare also rejects addresses below the base (they wrap high).
    assign off       = i_addr - BASE_ADDR;
    assign o_sel     = (off < 32'd20) && (off[1:0] == 2'b00);
    assign wr_acc    = i_wr_en && o_sel;
    assign rd_acc    = o_sel && !i_wr_en;
    assign full_mask = (i_wr_mask == 4'b1111);

    always_comb begin
        msip_d        = msip_q;
        mtimecmp_d    = mtimecmp_q;
        mtime_d       = mtime_q;
        cmp_stage_d   = cmp_stage_q;
        time_stage_d  = time_stage_q;
        snap_d        = snap_q;
        presc_d       = presc_q;
        rd_data_d     = rd_data_q;
        mtime_wr_d    = 1'b0;
        mtimecmp_wr_d = 1'b0;

        if (presc_q == PS_LAST) begin
            presc_d = '0;
            mtime_d = mtime_q + 64'd1;
        end else begin
            presc_d = presc_q + PW'(1);
        end

        // A committing mtime write overrides any tick in the same cycle.
        if (wr_acc) begin
            case (off[4:2])
                3'd0: if (i_wr_mask[0]) msip_d = i_wr_data[0];
                3'd1: if (full_mask) cmp_stage_d = i_wr_data;
                3'd2: if (full_mask) begin
                    mtimecmp_d    = {i_wr_data, cmp_stage_q};
                    mtimecmp_wr_d = 1'b1;
                end
                3'd3: if (full_mask) time_stage_d = i_wr_data;
                3'd4: if (full_mask) begin
                    mtime_d    = {i_wr_data, time_stage_q};
                    presc_d    = '0;
                    mtime_wr_d = 1'b1;
                end
                default: ;
            endcase
        end

        // Reading mtime_lo freezes the high word so a following mtime_hi read is coherent.
        if (rd_acc) begin
            case (off[4:2])
                3'd0: rd_data_d = {31'b0, msip_q};
                3'd1: rd_data_d = mtimecmp_q[31:0];
                3'd2: rd_data_d = mtimecmp_q[63:32];
                3'd3: begin
                    rd_data_d = mtime_q[31:0];
                    snap_d    = mtime_q[63:32];
                end
                3'd4: rd_data_d = snap_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            msip_q        <= 1'b0;
            mtimecmp_q    <= '1;
            mtime_q       <= '0;
            cmp_stage_q   <= '0;
            time_stage_q  <= '0;
            snap_q        <= '0;
            presc_q       <= '0;
            rd_data_q     <= '0;
            mtime_wr_q    <= 1'b0;
            mtimecmp_wr_q <= 1'b0;
        end else begin
            msip_q        <= msip_d;
            mtimecmp_q    <= mtimecmp_d;
            mtime_q       <= mtime_d;
            cmp_stage_q   <= cmp_stage_d;
            time_stage_q  <= time_stage_d;
            snap_q        <= snap_d;
            presc_q       <= presc_d;
            rd_data_q     <= rd_data_d;
            mtime_wr_q    <= mtime_wr_d;
            mtimecmp_wr_q <= mtimecmp_wr_d;
        end
    end

    assign o_rd_data            = rd_data_q;
    assign o_software_interrupt = msip_q;
    assign o_mtime_wr           = mtime_wr_q;
    assign o_mtimecmp_wr        = mtimecmp_wr_q;
    assign o_mtime_dout         = mtime_q;
    assign o_mtimecmp_dout      = mtimecmp_q;

endmodule
